// File: rtl/logic_axi4_stream_merge_if.sv
// Bus bundle for the packet-aware 2:1 AXI4-Stream merger.
// Carries both rx lanes and the single tx lane.
// The "slave" modport is the merger's view. The "master" modport is the
// view of the environment that feeds rx and drains tx.
interface logic_axi4_stream_merge_if #(
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);
  logic [1:0]                        rx_tvalid;
  logic [1:0]                        rx_tlast;
  logic [1:0][TDATA_BYTES-1:0][7:0]  rx_tdata;
  logic [1:0][TDATA_BYTES-1:0]       rx_tstrb;
  logic [1:0][TDATA_BYTES-1:0]       rx_tkeep;
  logic [1:0][TDEST_WIDTH-1:0]       rx_tdest;
  logic [1:0][TUSER_WIDTH-1:0]       rx_tuser;
  logic [1:0][TID_WIDTH-1:0]         rx_tid;
  logic [1:0]                        rx_tready;

  logic                              tx_tvalid;
  logic                              tx_tlast;
  logic [TDATA_BYTES-1:0][7:0]       tx_tdata;
  logic [TDATA_BYTES-1:0]            tx_tstrb;
  logic [TDATA_BYTES-1:0]            tx_tkeep;
  logic [TDEST_WIDTH-1:0]            tx_tdest;
  logic [TUSER_WIDTH-1:0]            tx_tuser;
  logic [TID_WIDTH-1:0]              tx_tid;
  logic                              tx_tready;

  modport slave (
    input  rx_tvalid, rx_tlast, rx_tdata, rx_tstrb, rx_tkeep,
    input  rx_tdest, rx_tuser, rx_tid,
    output rx_tready,
    output tx_tvalid, tx_tlast, tx_tdata, tx_tstrb, tx_tkeep,
    output tx_tdest, tx_tuser, tx_tid,
    input  tx_tready
  );

  modport master (
    output rx_tvalid, rx_tlast, rx_tdata, rx_tstrb, rx_tkeep,
    output rx_tdest, rx_tuser, rx_tid,
    input  rx_tready,
    input  tx_tvalid, tx_tlast, tx_tdata, tx_tstrb, tx_tkeep,
    input  tx_tdest, tx_tuser, tx_tid,
    output tx_tready
  );
endinterface

// File: rtl/logic_axi4_stream_merge.sv
// Packet-aware 2:1 AXI4-Stream merger.
// Whole packets are forwarded from one of two rx lanes to a single tx lane.
// Beats from different packets are never interleaved. The tx side is fully
// registered through an output register plus one skid register, so rx_tready
// never depends combinationally on tx_tready.
// Optional macro LOGIC_AXI4_STREAM_MERGE_ROUND_ROBIN_EN selects alternating
// arbitration. Without it, input 0 has fixed priority.
module logic_axi4_stream_merge #(
  parameter int TDATA_BYTES = 4,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int USE_TLAST   = 1,
  parameter int USE_TKEEP   = 1,
  parameter int USE_TSTRB   = 1
) (
  input  logic aclk,
  input  logic areset_n,
  logic_axi4_stream_merge_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic                        last;
    logic [TDATA_BYTES-1:0][7:0] data;
    logic [TDATA_BYTES-1:0]      strb;
    logic [TDATA_BYTES-1:0]      keep;
    logic [TDEST_WIDTH-1:0]      dest;
    logic [TUSER_WIDTH-1:0]      user;
    logic [TID_WIDTH-1:0]        id;
  } beat_t;

  state_t state, state_nxt;
  logic   owner;
  logic   run;
  logic   sel;
  logic   grant;
  logic   accept;
  beat_t  in_beat;

  logic   vld_p1;
  beat_t  out_p1;
  logic   skid_full;
  beat_t  skid_p1;

`ifdef LOGIC_AXI4_STREAM_MERGE_ROUND_ROBIN_EN
  logic   last;
`endif

  // Hold rx_tready low until the first clock edge after reset is released.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) run <= 1'b0;
    else           run <= 1'b1;
  end

  // Arbitration: the locked owner keeps the grant; in IDLE pick among valid inputs.
  always_comb begin
    sel   = 1'b0;
    grant = 1'b0;
    if (state == LOCKED) begin
      sel   = owner;
      grant = 1'b1;
    end else if (bus.rx_tvalid != 2'b00) begin
      grant = 1'b1;
`ifdef LOGIC_AXI4_STREAM_MERGE_ROUND_ROBIN_EN
      if (&bus.rx_tvalid) sel = ~last;
      else                sel = bus.rx_tvalid[1];
`else
      sel = ~bus.rx_tvalid[0];
`endif
    end
  end

  assign bus.rx_tready = (grant && !skid_full && run) ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign accept        = grant && !skid_full && run && bus.rx_tvalid[sel];

  // Build the beat from the granted lane, applying the disabled-field defaults.
  always_comb begin
    in_beat      = '0;
    in_beat.last = (USE_TLAST != 0) ? bus.rx_tlast[sel] : 1'b1;
    in_beat.data = bus.rx_tdata[sel];
    in_beat.strb = (USE_TSTRB != 0) ? bus.rx_tstrb[sel] : '1;
    in_beat.keep = (USE_TKEEP != 0) ? bus.rx_tkeep[sel] : '1;
    in_beat.dest = bus.rx_tdest[sel];
    in_beat.user = bus.rx_tuser[sel];
    in_beat.id   = bus.rx_tid[sel];
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // FSM next state: lock on a non-final beat, unlock on the final beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !in_beat.last) state_nxt = LOCKED;
      LOCKED:  if (accept &&  in_beat.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remember which input owns the packet in progress.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)                                        owner <= 1'b0;
    else if (accept && state == IDLE && !in_beat.last)    owner <= sel;
  end

`ifdef LOGIC_AXI4_STREAM_MERGE_ROUND_ROBIN_EN
  // Track the input that completed the most recent packet; reset favours input 0.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)                    last <= 1'b1;
    else if (accept && in_beat.last)  last <= sel;
  end
`endif

  // ---- output register and skid stage ----
  // Load the output register from skid or rx when it is free or draining;
  // otherwise park the accepted beat in skid.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      vld_p1    <= 1'b0;
      out_p1    <= '0;
      skid_full <= 1'b0;
      skid_p1   <= '0;
    end else if (!vld_p1 || bus.tx_tready) begin
      if (skid_full) begin
        out_p1    <= skid_p1;
        vld_p1    <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_p1 <= in_beat;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_p1   <= in_beat;
      skid_full <= 1'b1;
    end
  end

  assign bus.tx_tvalid = vld_p1;
  assign bus.tx_tlast  = out_p1.last;
  assign bus.tx_tdata  = out_p1.data;
  assign bus.tx_tstrb  = out_p1.strb;
  assign bus.tx_tkeep  = out_p1.keep;
  assign bus.tx_tdest  = out_p1.dest;
  assign bus.tx_tuser  = out_p1.user;
  assign bus.tx_tid    = out_p1.id;

endmodule
